// File: rtl/noise_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noise_pkg
//  Purpose  : Shared types, helpers and derived constants for the Gaussian
//             noise generator.
//  Revision : 1.0  initial release
// ============================================================================
package noise_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int c_OUT_TWOS   = 0;
    localparam int c_OUT_OFFSET = 1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int sum_w(input int n, input int w);
        return w + clog2(n);
    endfunction

    function automatic longint mean_sum(input int n, input int w);
        return longint'(n) << (w - 1);
    endfunction

    function automatic int lat(input int n);
        return clog2(n) + 2;
    endfunction

    localparam int     c_SUM_W    = sum_w(12, 12);
    localparam longint c_MEAN_SUM = mean_sum(12, 12);
    localparam int     c_LAT      = lat(12);

endpackage
`default_nettype wire

// File: rtl/adder_tree_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : adder_tree_pipe
//  Purpose  : Pipelined binary adder tree, one register per level, with a
//             valid tag travelling alongside the data.
//  Revision : 1.0  initial release
// ============================================================================
module adder_tree_pipe
    import noise_pkg::*;
#(
    parameter int N = 12,
    parameter int W = 12
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [N*W-1:0]             in_data,
    input  logic                       in_vld,
    output logic [W+clog2(N)-1:0]      sum_out,
    output logic                       sum_vld,
    output logic                       busy
);

    localparam int c_LVLS   = clog2(N);
    localparam int c_LEAVES = 1 << c_LVLS;
    localparam int c_SW     = W + c_LVLS;

    logic [c_SW-1:0]   w_src  [c_LVLS][c_LEAVES];
    logic [c_SW-1:0]   r_tree [c_LVLS][c_LEAVES/2];
    logic [c_LVLS-1:0] r_vld;

    // Level 0 reads zero-padded leaves; deeper levels read the previous register row.
    always_comb begin
        for (int lv = 0; lv < c_LVLS; lv++) begin
            for (int i = 0; i < c_LEAVES; i++) begin
                w_src[lv][i] = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            w_src[0][i] = {{c_LVLS{1'b0}}, in_data[i*W +: W]};
        end
        for (int lv = 1; lv < c_LVLS; lv++) begin
            for (int i = 0; i < c_LEAVES/2; i++) begin
                w_src[lv][i] = r_tree[lv-1][i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int lv = 0; lv < c_LVLS; lv++) begin
            for (int i = 0; i < (c_LEAVES >> (lv + 1)); i++) begin
                r_tree[lv][i] <= w_src[lv][2*i] + w_src[lv][2*i+1];
            end
        end
        if (RESET) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= in_vld;
            for (int lv = 1; lv < c_LVLS; lv++) begin
                r_vld[lv] <= r_vld[lv-1];
            end
        end
    end

    assign sum_out = r_tree[c_LVLS-1][0];
    assign sum_vld = r_vld[c_LVLS-1];
    assign busy    = |r_vld;

endmodule
`default_nettype wire

// File: rtl/gauss_noise_gen.sv
`default_nettype none
// ============================================================================
//  Module   : gauss_noise_gen
//  Purpose  : Central-limit Gaussian noise source: sum, de-mean, scale by
//             sigma, saturate, format and write to the noise FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module gauss_noise_gen
    import noise_pkg::*;
#(
    parameter int N_RND    = 12,
    parameter int RND_W    = 12,
    parameter int OUT_W    = 12,
    parameter int SIGMA_W  = 10,
    parameter int SHIFT    = 12,
    parameter int OUT_MODE = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic                   STOP,
    input  logic [SIGMA_W-1:0]     SIGMA,
    input  logic [N_RND*RND_W-1:0] RND_BUS,
    input  logic                   RND_VALID,
    input  logic                   FIFO_FULL,
    output logic                   FIFO_WR,
    output logic                   FIFO_SCLR,
    output logic [OUT_W-1:0]       NOISE_OUT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   OVERFLOW,
    output logic [15:0]            CLIP_CNT
);

    localparam int c_SUM_W = sum_w(N_RND, RND_W);
    localparam int c_PW    = c_SUM_W + SIGMA_W + 2;
    localparam logic [c_SUM_W:0] c_MEAN = (c_SUM_W+1)'(mean_sum(N_RND, RND_W));
    localparam logic signed [c_PW-1:0] c_QMAX = {{(c_PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_PW-1:0] c_QMIN = {{(c_PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t                  r_state;
    logic [SIGMA_W-1:0]      r_sigma;
    logic                    r_sclr;
    logic                    r_done;
    logic                    r_ovf;
    logic [15:0]             r_clip;
    logic                    r_wr;
    logic [OUT_W-1:0]        r_noise;
    logic                    r_mul_vld;
    logic signed [c_PW-1:0]  r_mul;

    logic                    w_inject;
    logic [c_SUM_W-1:0]      w_sum;
    logic                    w_sum_vld;
    logic                    w_tree_busy;
    logic signed [c_SUM_W:0] w_c;
    logic signed [c_PW-1:0]  w_p;
    logic signed [c_PW-1:0]  w_q;
    logic                    w_clip;
    logic [OUT_W-1:0]        w_sat;
    logic [OUT_W-1:0]        w_fmt;

    // The STOP cycle itself never injects, even with fresh random data present.
    assign w_inject = (r_state == RUN) && RND_VALID && !STOP;

    adder_tree_pipe #(
        .N (N_RND),
        .W (RND_W)
    ) u_tree (
        .CLK     (CLK),
        .RESET   (RESET),
        .in_data (RND_BUS),
        .in_vld  (w_inject),
        .sum_out (w_sum),
        .sum_vld (w_sum_vld),
        .busy    (w_tree_busy)
    );

    assign w_c    = $signed({1'b0, w_sum}) - $signed(c_MEAN);
    assign w_p    = w_c * $signed({1'b0, r_sigma});
    assign w_q    = r_mul >>> SHIFT;
    assign w_clip = (w_q > c_QMAX) || (w_q < c_QMIN);
    assign w_sat  = (w_q > c_QMAX) ? c_QMAX[OUT_W-1:0] :
                    (w_q < c_QMIN) ? c_QMIN[OUT_W-1:0] : w_q[OUT_W-1:0];
    // Offset binary is the two's complement code with its sign bit inverted.
    assign w_fmt  = {w_sat[OUT_W-1] ^ (OUT_MODE == c_OUT_OFFSET), w_sat[OUT_W-2:0]};

    always_ff @(posedge CLK) begin
        r_mul <= w_p;
        if (RESET) begin
            r_state   <= IDLE;
            r_sigma   <= '0;
            r_sclr    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_clip    <= '0;
            r_wr      <= 1'b0;
            r_noise   <= '0;
            r_mul_vld <= 1'b0;
        end else begin
            r_sclr    <= 1'b0;
            r_done    <= 1'b0;
            r_mul_vld <= w_sum_vld;
            r_wr      <= r_mul_vld && !FIFO_FULL;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_state <= RUN;
                        r_sigma <= SIGMA;
                        r_sclr  <= 1'b1;
                        r_ovf   <= 1'b0;
                        r_clip  <= '0;
                    end
                end
                RUN: begin
                    if (STOP) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!w_tree_busy && !r_mul_vld) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (r_mul_vld) begin
                if (FIFO_FULL) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_noise <= w_fmt;
                end
                if (w_clip && (r_clip != 16'hFFFF)) begin
                    r_clip <= r_clip + 16'd1;
                end
            end
        end
    end

    // Reset forces the quiescent output values in the very cycle it is asserted.
    assign FIFO_WR   = r_wr & ~RESET;
    assign FIFO_SCLR = r_sclr | RESET;
    assign NOISE_OUT = RESET ? '0 : r_noise;
    assign BUSY      = (r_state != IDLE) & ~RESET;
    assign DONE      = r_done & ~RESET;
    assign OVERFLOW  = r_ovf & ~RESET;
    assign CLIP_CNT  = RESET ? '0 : r_clip;

endmodule
`default_nettype wire

// File: tb/tb_gauss_noise_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gauss_noise_gen
//  Purpose  : Self-checking bench for gauss_noise_gen (two's complement and
//             offset-binary instances driven in parallel).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gauss_noise_gen;

    localparam int c_N   = 12;
    localparam int c_W   = 12;
    localparam int c_LAT = 6;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic [9:0]       SIGMA = '0;
    logic [c_N*c_W-1:0] RND_BUS = '0;
    logic             RND_VALID = 1'b0;
    logic             FIFO_FULL = 1'b0;

    logic             wr0, sclr0, busy0, done0, ovf0;
    logic [11:0]      noise0;
    logic [15:0]      clip0;
    logic             wr1, sclr1, busy1, done1, ovf1;
    logic [11:0]      noise1;
    logic [15:0]      clip1;

    gauss_noise_gen #(.OUT_MODE(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .SIGMA(SIGMA),
        .RND_BUS(RND_BUS), .RND_VALID(RND_VALID), .FIFO_FULL(FIFO_FULL),
        .FIFO_WR(wr0), .FIFO_SCLR(sclr0), .NOISE_OUT(noise0), .BUSY(busy0),
        .DONE(done0), .OVERFLOW(ovf0), .CLIP_CNT(clip0)
    );

    gauss_noise_gen #(.OUT_MODE(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .SIGMA(SIGMA),
        .RND_BUS(RND_BUS), .RND_VALID(RND_VALID), .FIFO_FULL(FIFO_FULL),
        .FIFO_WR(wr1), .FIFO_SCLR(sclr1), .NOISE_OUT(noise1), .BUSY(busy1),
        .DONE(done1), .OVERFLOW(ovf1), .CLIP_CNT(clip1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] in0;
        logic [11:0] rest;
        logic [9:0]  sigma;
        logic [11:0] exp;
        logic        clip;
    } vec_t;

    vec_t        vecs [9];
    logic [11:0] sb [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          last_wr_cyc = -1;
    int          first_wr_cyc = -1;
    bit          sb_en = 1'b1;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (wr0 === 1'b1) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (sb_en) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_write: got %0h expected no write", noise0);
                end else begin
                    logic [11:0] e;
                    e = sb.pop_front();
                    check("noise_twos", {20'd0, noise0}, {20'd0, e});
                    check("noise_offset", {20'd0, noise1}, {20'd0, e ^ 12'h800});
                    check("wr_offset", {31'd0, wr1}, 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_bus(input logic [11:0] in0, input logic [11:0] rest);
        for (int k = 0; k < c_N; k++) RND_BUS[k*c_W +: c_W] = (k == 0) ? in0 : rest;
    endtask

    task automatic start_run(input logic [9:0] s);
        SIGMA = s;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("sclr_after_start", {31'd0, sclr0}, 32'd1);
        check("busy_after_start", {31'd0, busy0}, 32'd1);
    endtask

    task automatic wait_done(output int dcyc, output logic busy_at);
        dcyc = -1;
        busy_at = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (done0 === 1'b1) begin
                dcyc = cyc;
                busy_at = busy0;
                break;
            end
        end
        if (dcyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE expected DONE within 60 cycles");
        end
        tick();
        check("done_one_cycle", {31'd0, done0}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int n, output int inj_cyc);
        int w0;
        int d;
        logic b;
        w0 = wr_cnt;
        start_run(v.sigma);
        set_bus(v.in0, v.rest);
        RND_VALID = 1'b1;
        inj_cyc = cyc + 1;
        for (int i = 0; i < n; i++) begin
            sb.push_back(v.exp);
            tick();
        end
        RND_VALID = 1'b0;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        wait_done(d, b);
        check("vec_writes", wr_cnt - w0, n);
        check("vec_clip_cnt", {16'd0, clip0}, v.clip ? n : 0);
        check("vec_overflow", {31'd0, ovf0}, 32'd0);
    endtask

    initial begin
        int inj;
        int d;
        int w0;
        int sc;
        logic b;

        vecs[0] = '{12'd2048, 12'd2048, 10'd682,  12'h000, 1'b0};
        vecs[1] = '{12'd2148, 12'd2048, 10'd682,  12'h010, 1'b0};
        vecs[2] = '{12'd1948, 12'd2048, 10'd682,  12'hFEF, 1'b0};
        vecs[3] = '{12'd4095, 12'd4095, 10'd682,  12'h7FF, 1'b1};
        vecs[4] = '{12'd0,    12'd0,    10'd682,  12'h800, 1'b1};
        vecs[5] = '{12'd2049, 12'd2048, 10'd1023, 12'h000, 1'b0};
        vecs[6] = '{12'd2047, 12'd2048, 10'd1023, 12'hFFF, 1'b0};
        vecs[7] = '{12'd4095, 12'd4095, 10'd0,    12'h000, 1'b0};
        vecs[8] = '{12'd4095, 12'd4095, 10'd1,    12'h005, 1'b0};

        // Reset state.
        repeat (3) tick();
        check("rst_wr", {31'd0, wr0}, 32'd0);
        check("rst_sclr", {31'd0, sclr0}, 32'd1);
        check("rst_noise", {20'd0, noise0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_ovf", {31'd0, ovf0}, 32'd0);
        check("rst_clip", {16'd0, clip0}, 32'd0);
        RESET = 1'b0;
        tick();
        check("idle_sclr", {31'd0, sclr0}, 32'd0);
        check("idle_busy", {31'd0, busy0}, 32'd0);

        // Table of arithmetic vectors; the first one also measures latency.
        first_wr_cyc = -1;
        for (int v = 0; v < 9; v++) begin
            run_vec(vecs[v], 3, inj);
            if (v == 0) check("latency", first_wr_cyc - inj, c_LAT - 1);
        end

        // Ten samples, STOP with RND_VALID still high; DONE right after last write.
        w0 = wr_cnt;
        start_run(10'd682);
        check("sclr_one_cycle_pre", {31'd0, sclr0}, 32'd1);
        set_bus(12'd2148, 12'd2048);
        RND_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sb.push_back(12'h010);
            tick();
            if (i == 0) check("sclr_one_cycle", {31'd0, sclr0}, 32'd0);
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        RND_VALID = 1'b0;
        wait_done(d, b);
        check("stop_writes", wr_cnt - w0, 10);
        check("done_after_last_wr", d - last_wr_cyc, 1);
        check("busy_falls_with_done", {31'd0, b}, 32'd0);

        // START and STOP together start only; empty DRAIN lasts one cycle.
        SIGMA = 10'd682;
        START = 1'b1;
        STOP = 1'b1;
        tick();
        START = 1'b0;
        STOP = 1'b0;
        repeat (5) tick();
        check("start_stop_busy", {31'd0, busy0}, 32'd1);
        STOP = 1'b1;
        sc = cyc;
        tick();
        STOP = 1'b0;
        wait_done(d, b);
        check("empty_drain_len", d - sc, 2);

        // Three cycles of FIFO_FULL mid-stream drop exactly three samples.
        sb_en = 1'b0;
        w0 = wr_cnt;
        start_run(10'd682);
        set_bus(12'd2048, 12'd2048);
        for (int i = 0; i < 20; i++) begin
            RND_VALID = 1'b1;
            FIFO_FULL = (i >= 10 && i < 13);
            tick();
        end
        FIFO_FULL = 1'b0;
        RND_VALID = 1'b0;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        wait_done(d, b);
        check("full_writes", wr_cnt - w0, 17);
        check("full_done_timing", d - last_wr_cyc, 1);
        check("ovf_sticky", {31'd0, ovf0}, 32'd1);
        repeat (3) tick();
        check("ovf_held_idle", {31'd0, ovf0}, 32'd1);
        start_run(10'd682);
        check("ovf_cleared", {31'd0, ovf0}, 32'd0);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        wait_done(d, b);

        // Reset with four samples in flight.
        sb_en = 1'b1;
        start_run(10'd682);
        set_bus(12'd2148, 12'd2048);
        RND_VALID = 1'b1;
        repeat (4) tick();
        RND_VALID = 1'b0;
        RESET = 1'b1;
        w0 = wr_cnt;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("mid_rst_wr", {31'd0, wr0}, 32'd0);
            check("mid_rst_sclr", {31'd0, sclr0}, 32'd1);
            check("mid_rst_busy", {31'd0, busy0}, 32'd0);
            check("mid_rst_noise", {20'd0, noise0}, 32'd0);
            check("mid_rst_clip", {16'd0, clip0}, 32'd0);
            tick();
        end
        RESET = 1'b0;
        sb.delete();
        repeat (12) tick();
        check("no_wr_after_rst", wr_cnt - w0, 0);
        check("idle_after_rst", {31'd0, busy0}, 32'd0);
        run_vec(vecs[2], 2, inj);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/gauss_noise_gen.md
# gauss_noise_gen

- Parametrised, pipelined Gaussian-noise generator: sums N_RND uniform random words (central-limit approximation), removes the exact mean, scales by a run-time sigma, saturates and formats for the DAC.
- Sits between the bank of uniform RNGs and the noise FIFO. Drives FIFO write/clear and carries run control, drain and overflow reporting.
- Next generation of the 12-input fixed-sigma summer: N_RND, widths, output format and sigma are now configurable; clipping and back-pressure are detected explicitly.

## Interface
Parameters
- N_RND, 12, number of uniform inputs summed (2..32)
- RND_W, 12, width of each uniform input (unsigned)
- OUT_W, 12, output sample width
- SIGMA_W, 10, width of SIGMA input (unsigned)
- SHIFT, 12, right-shift applied after sigma multiply
- OUT_MODE, 1, 0 = two's complement, 1 = offset binary (adds 2^(OUT_W-1))

Ports
- CLK in 1: clock
- RESET in 1: synchronous, active-high
- START in 1: begin run (honoured in IDLE only)
- STOP in 1: end run (honoured in RUN only)
- SIGMA in SIGMA_W: scale factor, latched on accepted START
- RND_BUS in N_RND*RND_W: packed uniform words, input k at bits [k*RND_W +: RND_W]
- RND_VALID in 1: RND_BUS holds a fresh set this cycle
- FIFO_FULL in 1: downstream FIFO full
- FIFO_WR out 1: write strobe, one per output sample
- FIFO_SCLR out 1: FIFO synchronous clear
- NOISE_OUT out OUT_W: sample, valid when FIFO_WR=1
- BUSY out 1: state != IDLE
- DONE out 1: one-cycle pulse on DRAIN->IDLE
- OVERFLOW out 1: sticky; a sample was dropped on FIFO_FULL
- CLIP_CNT out 16: saturating count of clipped samples in current run

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE --START--> RUN: latch SIGMA; clear OVERFLOW and CLIP_CNT; pulse FIFO_SCLR one cycle.
  - RUN --STOP--> DRAIN.
  - DRAIN --pipeline empty--> IDLE, with DONE pulse.
- Injection: in RUN only, each cycle with RND_VALID=1 enters one sample into the pipeline, tagged valid. RND_VALID is ignored in IDLE and DRAIN, including the cycle STOP is accepted.
- Arithmetic, all exact, no intermediate truncation:
  - S = sum of inputs, unsigned, width SUM_W = RND_W + clog2(N_RND).
  - C = S − N_RND·2^(RND_W−1), signed SUM_W+1.
  - P = C·SIGMA, signed.
  - Q = P >>> SHIFT (arithmetic, floor).
  - Saturate Q to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - If OUT_MODE=1, add 2^(OUT_W−1) mod 2^OUT_W.
- Clipping: a sample is clipped when saturation changes its value; CLIP_CNT increments and sticks at 0xFFFF.
- Back-pressure: a valid sample emerging while FIFO_FULL=1 is dropped. FIFO_WR stays 0 and OVERFLOW sets. The pipeline never stalls.
- Ignored inputs: START outside IDLE; STOP outside RUN. START and STOP together in IDLE: start only.
- Reset, including mid-run:
  - All pipeline valid tags clear and state goes to IDLE; no write occurs on or after the RESET cycle.
  - Output values during RESET: FIFO_WR=0, FIFO_SCLR=1, NOISE_OUT=0, BUSY=0, DONE=0, OVERFLOW=0, CLIP_CNT=0.

## Timing
- Pipeline latency LAT = clog2(N_RND) + 2 cycles (6 for defaults): one registered adder-tree level per log2 stage, one multiply stage, one offset/saturate/format stage.
- Data captured at edge t (RND_VALID=1, RUN) produces FIFO_WR=1 with NOISE_OUT over the cycle after edge t+LAT−1.
- Throughput is one sample per clock.
- FIFO_SCLR is high in the cycle after the accepting START edge. The first possible FIFO_WR is LAT cycles later.
- DRAIN lasts until the last in-flight sample has been written or dropped, then DONE for one cycle. If nothing is in flight, DRAIN lasts 1 cycle.
- NOISE_OUT holds its last value when FIFO_WR=0.

## Structure
- Shared package noise_pkg:
  - clog2 function
  - state enum (IDLE/RUN/DRAIN)
  - derived localparams SUM_W, MEAN_SUM, LAT
  - OUT_MODE constants
- Sub-module adder_tree_pipe: parametrised N inputs × W bits, registered per level, valid tag carried alongside. Top level holds FSM, multiply, saturate, FIFO and status logic.

## Test plan
1. Defaults, SIGMA=682, OUT_MODE=0, all inputs 2048, RND_VALID held → after LAT=6 cycles, continuous FIFO_WR with NOISE_OUT=0; OUT_MODE=1 gives 0x800.
2. Input0=2148, rest 2048 → NOISE_OUT=16. Input0=1948, rest 2048 → NOISE_OUT=−17 (0xFEF).
3. All 4095 → Q=4090, clipped to 2047. All 0 → −4092, clipped to −2048. CLIP_CNT increments per sample.
4. 10 valid cycles, STOP on cycle 10 → exactly 10 writes, DONE one cycle after the last write, BUSY falls with DONE.
5. FIFO_FULL high for 3 cycles mid-run → exactly 3 samples missing, OVERFLOW=1 until next START, no pipeline stall.
6. RESET asserted with 4 samples in flight → no FIFO_WR thereafter, FIFO_SCLR=1 during RESET, all other outputs at reset values. START after RESET resumes normally.
